// File: rtl/dpb_bank_arbiter.sv
// Circular bank arbiter between a JPEG writer and a UDP reader sharing a DPB.
// Banks are granted, filled, queued and drained strictly in ring order.
module dpb_bank_arbiter #(
  parameter int unsigned BANK_AW    = 4,
  parameter int unsigned BANK_BYTES = 2048
) (
  input  logic               i_pclk,
  input  logic               i_rst_n,
  input  logic               i_wr_req,
  output logic               o_wr_grant,
  output logic [BANK_AW-1:0] o_wr_bank,
  input  logic               i_wr_commit,
  input  logic [11:0]        i_wr_bytes,
  input  logic               i_wr_last,
  output logic               o_rd_valid,
  output logic [BANK_AW-1:0] o_rd_bank,
  output logic [11:0]        o_rd_bytes,
  output logic               o_rd_last,
  input  logic               i_rd_done,
  output logic [BANK_AW:0]   o_free_cnt,
  output logic [14:0]        o_frame_cnt,
  output logic [15:0]        o_drop_cnt,
  output logic               o_error
);

  localparam int unsigned NB = 1 << BANK_AW;
  localparam logic [BANK_AW:0]   NB_CNT    = (BANK_AW+1)'(NB);
  localparam logic [BANK_AW:0]   CNT_ONE   = (BANK_AW+1)'(1);
  localparam logic [BANK_AW-1:0] PTR_ONE   = (BANK_AW)'(1);
  localparam logic [11:0]        MAX_BYTES = 12'(BANK_BYTES);

  typedef enum logic [0:0] {W_IDLE, W_OWN} wstate_e;

  wstate_e            state_q, state_d;
  logic [BANK_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [BANK_AW:0]   qcnt_q, qcnt_d;
  logic [11:0]        bytes_q [NB];
  logic [11:0]        bytes_d [NB];
  logic               last_q  [NB];
  logic               last_d  [NB];
  logic               grant_q, grant_d;
  logic [BANK_AW-1:0] wr_bank_q, wr_bank_d;
  logic               rd_valid_q, rd_valid_d;
  logic [BANK_AW-1:0] rd_bank_q, rd_bank_d;
  logic [11:0]        rd_bytes_q, rd_bytes_d;
  logic               rd_last_q, rd_last_d;
  logic [14:0]        frame_q, frame_d;
  logic [15:0]        drop_q, drop_d;
  logic               error_q, error_d;

  logic             pop, push;
  logic [BANK_AW:0] pop_cnt, push_cnt, own_cnt;
  logic [11:0]      bytes_in;

  assign pop      = i_rd_done & rd_valid_q;
  assign pop_cnt  = pop ? CNT_ONE : '0;
  assign own_cnt  = (state_q == W_OWN) ? CNT_ONE : '0;
  assign bytes_in = (i_wr_bytes > MAX_BYTES) ? MAX_BYTES : i_wr_bytes;

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    bytes_d   = bytes_q;
    last_d    = last_q;
    grant_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    frame_d   = frame_q;
    drop_d    = drop_q;
    error_d   = error_q;
    push      = 1'b0;

    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end

    unique case (state_q)
      W_IDLE: begin
        if (i_wr_req) begin
          // A bank freed by this cycle's pop may be handed out immediately.
          if ((qcnt_q - pop_cnt) < NB_CNT) begin
            grant_d   = 1'b1;
            wr_bank_d = wp_q;
            state_d   = W_OWN;
          end else begin
            if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end
            error_d = 1'b1;
          end
        end
        if (i_wr_commit) begin
          error_d = 1'b1;
        end
      end
      W_OWN: begin
        if (i_wr_req) begin
          error_d = 1'b1;
        end
        if (i_wr_commit) begin
          state_d = W_IDLE;
          // An empty, non-final bank is simply handed back to the free pool.
          if ((i_wr_bytes != 12'd0) || i_wr_last) begin
            push          = 1'b1;
            bytes_d[wp_q] = bytes_in;
            last_d[wp_q]  = i_wr_last;
            wp_d          = wp_q + PTR_ONE;
            if (i_wr_last) begin
              frame_d = frame_q + 15'd1;
            end
            if (i_wr_bytes > MAX_BYTES) begin
              error_d = 1'b1;
            end
          end
        end
      end
      default: state_d = W_IDLE;
    endcase

    push_cnt = push ? CNT_ONE : '0;
    qcnt_d   = qcnt_q + push_cnt - pop_cnt;

    // Head metadata comes from next-state storage so a same-cycle commit is visible.
    rd_valid_d = (qcnt_d != '0);
    rd_bank_d  = rp_d;
    rd_bytes_d = bytes_d[rp_d];
    rd_last_d  = last_d[rp_d];
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= W_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      qcnt_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        bytes_q[i] <= '0;
        last_q[i]  <= 1'b0;
      end
      grant_q    <= 1'b0;
      wr_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
      rd_bytes_q <= '0;
      rd_last_q  <= 1'b0;
      frame_q    <= '0;
      drop_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      qcnt_q     <= qcnt_d;
      bytes_q    <= bytes_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      wr_bank_q  <= wr_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      rd_bytes_q <= rd_bytes_d;
      rd_last_q  <= rd_last_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
      error_q    <= error_d;
    end
  end

  assign o_wr_grant  = grant_q;
  assign o_wr_bank   = wr_bank_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_bank   = rd_bank_q;
  assign o_rd_bytes  = rd_bytes_q;
  assign o_rd_last   = rd_last_q;
  assign o_free_cnt  = NB_CNT - qcnt_q - own_cnt;
  assign o_frame_cnt = frame_q;
  assign o_drop_cnt  = drop_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_dpb_bank_arbiter.sv
// Scoreboard bench for dpb_bank_arbiter: a behavioural ring model predicts grants,
// queue heads and counters, checked one cycle after each stimulus edge.
module tb_dpb_bank_arbiter;

  logic        i_pclk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_req = 1'b0;
  logic        o_wr_grant;
  logic [3:0]  o_wr_bank;
  logic        i_wr_commit = 1'b0;
  logic [11:0] i_wr_bytes = '0;
  logic        i_wr_last = 1'b0;
  logic        o_rd_valid;
  logic [3:0]  o_rd_bank;
  logic [11:0] o_rd_bytes;
  logic        o_rd_last;
  logic        i_rd_done = 1'b0;
  logic [4:0]  o_free_cnt;
  logic [14:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_error;

  dpb_bank_arbiter #(.BANK_AW(4), .BANK_BYTES(2048)) dut (
    .i_pclk      (i_pclk),
    .i_rst_n     (i_rst_n),
    .i_wr_req    (i_wr_req),
    .o_wr_grant  (o_wr_grant),
    .o_wr_bank   (o_wr_bank),
    .i_wr_commit (i_wr_commit),
    .i_wr_bytes  (i_wr_bytes),
    .i_wr_last   (i_wr_last),
    .o_rd_valid  (o_rd_valid),
    .o_rd_bank   (o_rd_bank),
    .o_rd_bytes  (o_rd_bytes),
    .o_rd_last   (o_rd_last),
    .i_rd_done   (i_rd_done),
    .o_free_cnt  (o_free_cnt),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt),
    .o_error     (o_error)
  );

  always #5 i_pclk = ~i_pclk;

  typedef struct {
    logic [3:0]  bank;
    logic [11:0] bytes;
    logic        last;
  } rd_ent_t;

  rd_ent_t    m_rdq[$];
  logic [3:0] exp_grant_q[$];
  logic [3:0] m_wp;
  logic       m_own;
  logic [14:0] m_frame;
  logic [15:0] m_drop;
  logic       m_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_rdq.delete();
    exp_grant_q.delete();
    m_wp = '0; m_own = 1'b0; m_frame = '0; m_drop = '0; m_err = 1'b0;
  endtask

  // Called at #1 after an edge; compares outputs produced by that edge.
  task automatic check_outputs();
    if (exp_grant_q.size() != 0) begin
      check_eq("wr_grant", 32'(o_wr_grant), 32'd1);
      check_eq("wr_bank", 32'(o_wr_bank), 32'(exp_grant_q.pop_front()));
    end else begin
      check_eq("no_grant", 32'(o_wr_grant), 32'd0);
    end
    check_eq("rd_valid", 32'(o_rd_valid), 32'(m_rdq.size() != 0));
    if (m_rdq.size() != 0) begin
      check_eq("rd_bank", 32'(o_rd_bank), 32'(m_rdq[0].bank));
      check_eq("rd_bytes", 32'(o_rd_bytes), 32'(m_rdq[0].bytes));
      check_eq("rd_last", 32'(o_rd_last), 32'(m_rdq[0].last));
    end
    check_eq("free_cnt", 32'(o_free_cnt), 32'(16 - m_rdq.size() - int'(m_own)));
    check_eq("frame_cnt", 32'(o_frame_cnt), 32'(m_frame));
    check_eq("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
    check_eq("error", 32'(o_error), 32'(m_err));
  endtask

  task automatic drive(input logic req, input logic commit, input logic [11:0] bytes,
                       input logic last, input logic done);
    bit pop, own0;
    rd_ent_t ent;
    i_wr_req = req; i_wr_commit = commit; i_wr_bytes = bytes; i_wr_last = last;
    i_rd_done = done;
    pop  = done && (m_rdq.size() != 0);
    own0 = m_own;
    if (req) begin
      if (own0) m_err = 1'b1;
      else if (m_rdq.size() - int'(pop) < 16) begin
        exp_grant_q.push_back(m_wp);
        m_own = 1'b1;
      end else begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_err = 1'b1;
      end
    end
    if (commit) begin
      if (!own0) m_err = 1'b1;
      else begin
        m_own = 1'b0;
        if (bytes != 0 || last) begin
          ent.bank  = m_wp;
          ent.bytes = (bytes > 12'd2048) ? 12'd2048 : bytes;
          ent.last  = last;
          m_rdq.push_back(ent);
          m_wp++;
          if (last) m_frame++;
          if (bytes > 12'd2048) m_err = 1'b1;
        end
      end
    end
    if (pop) void'(m_rdq.pop_front());
    @(posedge i_pclk);
    #1;
    i_wr_req = 1'b0; i_wr_commit = 1'b0; i_wr_bytes = '0; i_wr_last = 1'b0;
    i_rd_done = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_wr_req = 1'b0; i_wr_commit = 1'b0; i_wr_bytes = '0; i_wr_last = 1'b0;
    i_rd_done = 1'b0;
    model_clear();
    #2;
    check_eq("rst_grant", 32'(o_wr_grant), 32'd0);
    check_eq("rst_wr_bank", 32'(o_wr_bank), 32'd0);
    check_eq("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("rst_rd_bank", 32'(o_rd_bank), 32'd0);
    check_eq("rst_rd_bytes", 32'(o_rd_bytes), 32'd0);
    check_eq("rst_rd_last", 32'(o_rd_last), 32'd0);
    check_eq("rst_free", 32'(o_free_cnt), 32'd16);
    check_eq("rst_frame", 32'(o_frame_cnt), 32'd0);
    check_eq("rst_drop", 32'(o_drop_cnt), 32'd0);
    check_eq("rst_error", 32'(o_error), 32'd0);
    @(negedge i_pclk);
    i_rst_n = 1'b1;
    @(posedge i_pclk);
    #1;
    check_outputs();
  endtask

  logic [11:0] rb;

  initial begin
    model_clear();
    do_reset();

    // Basic grant / commit / read-out.
    drive(1, 0, 12'd0, 0, 0);
    drive(0, 1, 12'd2048, 0, 0);
    check_eq("basic_free15", 32'(o_free_cnt), 32'd15);
    drive(0, 0, 12'd0, 0, 1);

    // Fill every bank, then overflow and full-queue grant on coincident pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 12'd0, 0, 0);
      drive(0, 1, 12'(100 + i), 0, 0);
    end
    drive(1, 0, 12'd0, 0, 0);
    check_eq("full_drop1", 32'(o_drop_cnt), 32'd1);
    check_eq("full_err", 32'(o_error), 32'd1);
    check_eq("full_free0", 32'(o_free_cnt), 32'd0);
    drive(1, 0, 12'd0, 0, 1);
    check_eq("full_pop_drop", 32'(o_drop_cnt), 32'd1);
    drive(0, 1, 12'd7, 1, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 12'd0, 0, 1);
    drive(0, 0, 12'd0, 0, 1);

    // Twenty banks around the ring with commits coinciding with pops.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 12'd0, 0, 0);
      drive(0, 1, 12'(16 * (i + 1)), (i % 5) == 4, (i % 2) == 1);
    end
    check_eq("ring_frames", 32'(o_frame_cnt), 32'd4);
    for (int i = 0; i < 12; i++) drive(0, 0, 12'd0, 0, 1);

    // Empty release, oversize clamp, protocol errors, pop on empty queue.
    do_reset();
    drive(0, 0, 12'd0, 0, 1);
    drive(1, 0, 12'd0, 0, 0);
    drive(0, 1, 12'd0, 0, 0);
    drive(1, 0, 12'd0, 0, 0);
    check_eq("reuse_bank0", 32'(o_wr_bank), 32'd0);
    drive(0, 1, 12'd3000, 1, 0);
    check_eq("clamp_bytes", 32'(o_rd_bytes), 32'd2048);
    check_eq("clamp_err", 32'(o_error), 32'd1);
    do_reset();
    drive(0, 1, 12'd5, 0, 0);
    do_reset();
    drive(1, 0, 12'd0, 0, 0);
    drive(1, 0, 12'd0, 0, 0);
    drive(0, 1, 12'd9, 0, 0);

    // Reset while three banks are queued and the writer owns a fourth.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 12'd0, 0, 0);
      drive(0, 1, 12'(50 + i), i == 2, 0);
    end
    drive(1, 0, 12'd0, 0, 0);
    do_reset();
    drive(1, 0, 12'd0, 0, 0);
    drive(0, 1, 12'd1, 0, 0);

    // Random traffic including illegal requests and oversize commits.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = 12'd0;
        1:       rb = 12'($urandom_range(2049, 4095));
        default: rb = 12'($urandom_range(1, 2048));
      endcase
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2, rb,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
